// File: rtl/gem_ext_fifo_tx_sf.sv
`default_nettype none
// ============================================================================
//  Module   : gem_ext_fifo_tx_sf
//  Purpose  : Store-and-forward transmit FIFO between an AXI-Stream byte
//             source and the GEM MAC external FIFO interface. Frames become
//             visible to the MAC only once complete. A frame that overflows
//             the buffer is dropped whole. The optional cut-through mode is
//             enabled by defining GEM_TX_CUT_THROUGH_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module gem_ext_fifo_tx_sf #(
    parameter int ADDR_W = 11,
    parameter int FCNT_W = 6
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [7:0]        s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tuser,
    output logic [7:0]        gem_data,
    output logic              gem_data_ready,
    output logic              gem_data_valid,
    input  logic              gem_data_rd_request,
    output logic              gem_sop,
    output logic              gem_eop,
    output logic              gem_err,
    output logic              gem_underflow,
    output logic              gem_flushed,
    input  logic              gem_dma_tx_end_tog,
    output logic              gem_dma_tx_status_tog,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int              c_depth    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] c_ptr_one  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [FCNT_W-1:0] c_cnt_one = {{(FCNT_W-1){1'b0}}, 1'b1};
    localparam logic [1:0]      c_st_idle     = 2'd0;
    localparam logic [1:0]      c_st_send     = 2'd1;
    localparam logic [1:0]      c_st_wait_end = 2'd2;

    // Entry layout: {err, last, data}
    logic [9:0]        r_mem [c_depth];
    logic [ADDR_W:0]   r_wr_ptr, r_rd_ptr, r_frame_start;
    logic              r_drop, r_commit, r_active;
    logic [FCNT_W-1:0] r_frame_cnt, r_end_pend;
    logic [1:0]        r_state;
    logic [7:0]        r_data;
    logic              r_valid, r_sop, r_eop, r_err, r_underflow, r_flushed;
    logic              r_flush, r_end_q, r_end_q2, r_status;

    logic              w_full, w_empty, w_mid, w_cnt_ok, w_ovf, w_tready;
    logic              w_accept, w_wr_en, w_ct_ready, w_ct_hold;
    logic              w_ready, w_req, w_take, w_dec, w_end_chg;
    logic [9:0]        w_entry;

    assign w_full   = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                      (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_mid    = (r_wr_ptr != r_frame_start);
    assign w_cnt_ok = (r_frame_cnt != {FCNT_W{1'b1}});

`ifdef GEM_TX_CUT_THROUGH_EN
    logic              r_ct;
    logic [ADDR_W:0]   w_fill;
    assign w_fill     = r_wr_ptr - r_frame_start;
    // Only start cut-through when the open frame sits at the head of the buffer
    assign w_ct_ready = (r_frame_cnt == '0) && !r_commit && !r_drop &&
                        (32'(w_fill) >= 32'd64);
    // The open frame is being read, so it cannot be rewound; stall instead
    assign w_ct_hold  = r_ct;
`else
    assign w_ct_ready = 1'b0;
    assign w_ct_hold  = 1'b0;
`endif

    // A full buffer with a partial frame in it means that frame can never fit
    assign w_ovf    = w_full && w_mid && !w_ct_hold;
    assign w_tready = r_active && (r_drop || w_ovf || (!w_full && w_cnt_ok));
    assign w_accept = s_axis_tvalid && w_tready;
    assign w_wr_en  = w_accept && !r_drop && !w_ovf;

    // Write pointer, frame start marker, drop mode and commit pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_active      <= 1'b0;
            r_wr_ptr      <= '0;
            r_frame_start <= '0;
            r_drop        <= 1'b0;
            r_commit      <= 1'b0;
        end else begin
            r_active <= 1'b1;
            r_commit <= w_wr_en && s_axis_tlast;
            if (w_accept) begin
                if (r_drop || w_ovf) begin
                    r_wr_ptr <= r_frame_start;
                    r_drop   <= !s_axis_tlast;
                end else begin
                    r_wr_ptr <= r_wr_ptr + c_ptr_one;
                    if (s_axis_tlast) begin
                        r_frame_start <= r_wr_ptr + c_ptr_one;
                    end
                end
            end
        end
    end

    // Byte storage; no reset so it can map onto RAM
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= {s_axis_tuser & s_axis_tlast, s_axis_tlast, s_axis_tdata};
        end
    end

    assign w_entry   = r_mem[r_rd_ptr[ADDR_W-1:0]];
    assign w_ready   = ((r_state == c_st_idle) && ((r_frame_cnt != '0) || w_ct_ready)) ||
                       ((r_state == c_st_send) && !r_flush);
    assign w_req     = gem_data_rd_request && w_ready;
    assign w_take    = !w_empty && (w_req || ((r_state == c_st_send) && r_flush));
    assign w_dec     = w_take && w_entry[8];
    assign w_end_chg = r_end_q ^ r_end_q2;

    // Committed frame count: +1 one cycle after tlast, -1 when an eop entry leaves
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_frame_cnt <= '0;
        end else begin
            unique case ({r_commit, w_dec})
                2'b10:   r_frame_cnt <= r_frame_cnt + c_cnt_one;
                2'b01:   r_frame_cnt <= r_frame_cnt - c_cnt_one;
                default: r_frame_cnt <= r_frame_cnt;
            endcase
        end
    end

    // Read FSM, registered MAC outputs and end/status toggle handshake
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= c_st_idle;
            r_rd_ptr    <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_sop       <= 1'b0;
            r_eop       <= 1'b0;
            r_err       <= 1'b0;
            r_underflow <= 1'b0;
            r_flushed   <= 1'b0;
            r_flush     <= 1'b0;
            r_end_q     <= 1'b0;
            r_end_q2    <= 1'b0;
            r_status    <= 1'b0;
            r_end_pend  <= '0;
`ifdef GEM_TX_CUT_THROUGH_EN
            r_ct        <= 1'b0;
`endif
        end else begin
            r_valid     <= 1'b0;
            r_sop       <= 1'b0;
            r_eop       <= 1'b0;
            r_err       <= 1'b0;
            r_underflow <= 1'b0;
            r_flushed   <= 1'b0;
            r_end_q     <= gem_dma_tx_end_tog;
            r_end_q2    <= r_end_q;
            // Every end toggle is echoed, whatever the state
            r_status    <= r_status ^ w_end_chg;
            if (w_take) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            // End toggles arriving outside WAIT_END are banked for later
            if (w_end_chg && (r_state != c_st_wait_end)) begin
                r_end_pend <= r_end_pend + c_cnt_one;
            end
            unique case (r_state)
                c_st_idle: begin
                    if (w_req) begin
                        r_data  <= w_entry[7:0];
                        r_valid <= 1'b1;
                        r_sop   <= 1'b1;
                        r_eop   <= w_entry[8];
                        r_err   <= w_entry[9];
                        r_state <= w_entry[8] ? c_st_wait_end : c_st_send;
`ifdef GEM_TX_CUT_THROUGH_EN
                        r_ct    <= (r_frame_cnt == '0);
`endif
                    end
                end
                c_st_send: begin
                    if (r_flush) begin
                        if (w_take && w_entry[8]) begin
                            r_flushed <= 1'b1;
                            r_flush   <= 1'b0;
                            r_state   <= c_st_wait_end;
`ifdef GEM_TX_CUT_THROUGH_EN
                            r_ct      <= 1'b0;
`endif
                        end
                    end else if (w_req) begin
                        if (w_empty) begin
`ifdef GEM_TX_CUT_THROUGH_EN
                            r_underflow <= 1'b1;
                            r_flush     <= 1'b1;
`endif
                        end else begin
                            r_data  <= w_entry[7:0];
                            r_valid <= 1'b1;
                            r_eop   <= w_entry[8];
                            r_err   <= w_entry[9];
                            if (w_entry[8]) begin
                                r_state <= c_st_wait_end;
`ifdef GEM_TX_CUT_THROUGH_EN
                                r_ct    <= 1'b0;
`endif
                            end
                        end
                    end
                end
                c_st_wait_end: begin
                    if (w_end_chg) begin
                        r_state <= c_st_idle;
                    end else if (r_end_pend != '0) begin
                        r_end_pend <= r_end_pend - c_cnt_one;
                        r_state    <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign s_axis_tready         = w_tready;
    assign gem_data              = r_data;
    assign gem_data_ready        = w_ready && !r_flush;
    assign gem_data_valid        = r_valid;
    assign gem_sop               = r_sop;
    assign gem_eop               = r_eop;
    assign gem_err               = r_err;
    assign gem_underflow         = r_underflow;
    assign gem_flushed           = r_flushed;
    assign gem_dma_tx_status_tog = r_status;
    assign frame_cnt             = r_frame_cnt;

endmodule
`default_nettype wire

// File: doc/gem_ext_fifo_tx_sf.md
GEM_EXT_FIFO_TX_SF -- requirements
Module: gem_ext_fifo_tx_sf

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, byte buffer depth 2**ADDR_W.
REQ-002 SHALL have parameter FCNT_W, default 6, width of the committed-frame counter.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rstn  in  1  reset, asynchronous, active-low.
REQ-005 s_axis_tdata  in  8  frame byte.
REQ-006 s_axis_tvalid  in  1  byte valid.
REQ-007 s_axis_tready  out  1  byte accepted when tvalid&tready.
REQ-008 s_axis_tlast  in  1  last byte of frame.
REQ-009 s_axis_tuser  in  1  frame error, sampled with tlast.
REQ-010 gem_data  out  8  byte to MAC, registered.
REQ-011 gem_data_ready  out  1  frame available to MAC.
REQ-012 gem_data_valid  out  1  gem_data valid, one cycle per byte.
REQ-013 gem_data_rd_request  in  1  MAC byte request, one cycle per byte.
REQ-014 gem_sop  out  1  with first byte of frame.
REQ-015 gem_eop  out  1  with last byte of frame.
REQ-016 gem_err  out  1  with last byte if frame tuser was set.
REQ-017 gem_underflow  out  1  one-cycle pulse, MAC read an empty buffer mid-frame.
REQ-018 gem_flushed  out  1  one-cycle pulse, remainder of frame discarded.
REQ-019 gem_dma_tx_end_tog  in  1  MAC toggles at end of each frame.
REQ-020 gem_dma_tx_status_tog  out  1  toggled once per received end toggle.
REQ-021 frame_cnt  out  FCNT_W  committed frames not yet fully read.

Function
REQ-022 Buffer SHALL store 10 bits/entry: data, last, err; pointers ADDR_W+1 bits, full/empty by MSB compare.
REQ-023 s_axis_tready SHALL be 1 when buffer not full and frame_cnt < max, or while DROP active.
REQ-024 Frame SHALL commit (frame_cnt+1) on cycle after tlast accepted; rd side decrements on eop; simultaneous inc/dec leaves frame_cnt unchanged.
REQ-025 Buffer full mid-frame SHALL set DROP: wr pointer rewound to frame start, bytes discarded up to and including tlast, no commit.
REQ-026 Read FSM states IDLE, SEND, WAIT_END; reset state IDLE.
REQ-027 IDLE: gem_data_ready=1 iff frame_cnt>0; first rd_request -> SEND.
REQ-028 Each rd_request SHALL yield gem_data_valid exactly 1 cycle later with byte; sop on first, eop and err on last.
REQ-029 After eop SHALL deassert gem_data_ready and enter WAIT_END; rd_request there ignored.
REQ-030 WAIT_END: on change of registered gem_dma_tx_end_tog, toggle gem_dma_tx_status_tog next cycle, -> IDLE.
REQ-031 End toggle change in IDLE/SEND SHALL still be echoed; no toggle lost.
REQ-032 Frames SHALL leave in arrival order; back-to-back frames need one IDLE cycle minimum.

Reset
REQ-033 rstn low SHALL asynchronously clear pointers, frame_cnt, DROP, FSM to IDLE, all outputs 0, s_axis_tready 0.
REQ-034 Reset mid-frame SHALL discard all buffered bytes; first frame after release starts with sop.

Configuration
REQ-035 Macro GEM_TX_CUT_THROUGH_EN defined: gem_data_ready also asserts when uncommitted frame has >=64 bytes buffered.
REQ-036 With it, rd_request on empty buffer mid-frame SHALL pulse gem_underflow, issue no gem_data_valid, discard rest of frame to tlast, then pulse gem_flushed, -> WAIT_END.
REQ-037 Macro undefined: store-and-forward only; gem_underflow and gem_flushed constant 0.

Verification
REQ-038 60-byte frame, rd_request every 4 cycles -> 60 valids, sop byte 0, eop byte 59, frame_cnt 1->0.
REQ-039 ADDR_W=6, 100-byte frame -> tready stays 1, frame dropped, frame_cnt 0, next 10-byte frame delivered intact.
REQ-040 Frame with tuser=1 on tlast -> gem_err=1 only with eop byte.
REQ-041 Two 20-byte frames, end_tog toggled after each -> two status toggles, frames ordered.
REQ-042 rstn low after 30 of 50 bytes -> outputs 0 immediately; next frame delivers sop.
REQ-043 GEM_TX_CUT_THROUGH_EN, 64 bytes written then stall, MAC reads 65 -> underflow pulse, flushed pulse after tlast.
